// File: rtl/uiip_checksum_sched_pkg.sv
// Shared definitions for the IP header checksum scheduler.
//   state_e          : scheduler FSM state encoding (also driven out on the debug port)
//   MAX_WORDS_DEF    : default job length limit in 16-bit words (20-byte IPv4 header)
//   ones_add16()     : 16-bit one's-complement add with end-around carry
package uiip_checksum_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_ACCUM = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int MAX_WORDS_DEF = 10;

   // The carry out of bit 15 is folded straight back in. A second carry is
   // impossible: the largest low half after a carry is 16'hFFFE.
   function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[15:0] + {15'd0, s[16]};
   endfunction

endpackage

// File: rtl/uiip_checksum_sched_ones_add16.sv
// Combinational 16-bit one's-complement adder (end-around carry).
//   I_a, I_b : addends
//   O_sum    : low16(I_a + I_b) + carry
module uiip_ones_add16
   import uiip_checksum_sched_pkg::*;
(
   input  logic [15:0] I_a,
   input  logic [15:0] I_b,
   output logic [15:0] O_sum
);

   assign O_sum = ones_add16(I_a, I_b);

endmodule

// File: rtl/uiip_checksum_sched.sv
// Two-requester round-robin scheduler around a single IP header checksum engine.
//   I_clk, I_reset                  : clock, async active-high reset
//   I_reqN / O_gntN                 : job request (held for the whole job) / ownership
//   I_validN, I_dataN, I_lastN      : word strobe, big-endian header word, final-word flag
//   O_cksum, O_cksum_valid          : inverted folded sum, one-cycle result pulse
//   O_cksum_owner, O_cksum_zero     : requester of the result/error, result == 0
//   O_err                           : one-cycle pulse when a job exceeds MAX_WORDS
//   O_busy                          : FSM not in IDLE
//   O_dbg_state                     : current FSM state
// Handshake: a word is consumed on every rising edge where the FSM is in ACCUM,
// the requester owns the engine and its I_validN is high; there is no back-pressure.
module uiip_checksum_sched
   import uiip_checksum_sched_pkg::*;
#(
   parameter int MAX_WORDS = MAX_WORDS_DEF
) (
   input  logic        I_clk,
   input  logic        I_reset,
   input  logic        I_req0,
   input  logic        I_req1,
   output logic        O_gnt0,
   output logic        O_gnt1,
   input  logic        I_valid0,
   input  logic        I_valid1,
   input  logic [15:0] I_data0,
   input  logic [15:0] I_data1,
   input  logic        I_last0,
   input  logic        I_last1,
   output logic [15:0] O_cksum,
   output logic        O_cksum_valid,
   output logic        O_cksum_owner,
   output logic        O_cksum_zero,
   output logic        O_err,
   output logic        O_busy,
   output logic [1:0]  O_dbg_state
);

   localparam int CW = $clog2(MAX_WORDS + 1);

   state_e        state_q, state_d;
   logic          owner_q, owner_d;
   logic          rr_q, rr_d;      // requester favoured when both ask at once
   logic [15:0]   accum_q, accum_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   cksum_q, cksum_d;
   logic          err_q, err_d;

   logic          sel_req, sel_valid, sel_last;
   logic [15:0]   sel_data, add_sum;
   logic          in_job;

   // Only the owner's lane ever reaches the adder.
   assign sel_req   = owner_q ? I_req1   : I_req0;
   assign sel_valid = owner_q ? I_valid1 : I_valid0;
   assign sel_last  = owner_q ? I_last1  : I_last0;
   assign sel_data  = owner_q ? I_data1  : I_data0;

   uiip_ones_add16 u_add (
      .I_a   (accum_q),
      .I_b   (sel_data),
      .O_sum (add_sum)
   );

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      accum_d = accum_q;
      cnt_d   = cnt_q;
      cksum_d = cksum_q;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (I_req0 || I_req1) begin
               state_d = ST_GRANT;
               owner_d = (I_req0 && I_req1) ? rr_q : I_req1;
            end
         end
         ST_GRANT: begin
            accum_d = '0;
            cnt_d   = '0;
            state_d = sel_req ? ST_ACCUM : ST_IDLE;
         end
         ST_ACCUM: begin
            if (!sel_req) begin
               // Abort: partial sum is simply abandoned, pointer untouched.
               state_d = ST_IDLE;
            end else if (sel_valid) begin
               if (sel_last) begin
                  accum_d = add_sum;
                  cksum_d = ~add_sum;
                  state_d = ST_DONE;
               end else if (cnt_q == CW'(MAX_WORDS)) begin
                  err_d   = 1'b1;
                  rr_d    = ~owner_q;
                  state_d = ST_IDLE;
               end else begin
                  accum_d = add_sum;
                  cnt_d   = cnt_q + 1'b1;
               end
            end
         end
         ST_DONE: begin
            rr_d    = ~owner_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge I_clk or posedge I_reset) begin
      if (I_reset) begin
         state_q <= ST_IDLE;
         owner_q <= 1'b0;
         rr_q    <= 1'b0;
         accum_q <= '0;
         cnt_q   <= '0;
         cksum_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         accum_q <= accum_d;
         cnt_q   <= cnt_d;
         cksum_q <= cksum_d;
         err_q   <= err_d;
      end
   end

   assign in_job        = (state_q == ST_GRANT) || (state_q == ST_ACCUM);
   assign O_gnt0        = in_job && !owner_q;
   assign O_gnt1        = in_job &&  owner_q;
   assign O_cksum       = cksum_q;
   assign O_cksum_valid = (state_q == ST_DONE);
   assign O_cksum_zero  = (state_q == ST_DONE) && (cksum_q == 16'h0000);
   assign O_cksum_owner = owner_q;
   assign O_err         = err_q;
   assign O_busy        = (state_q != ST_IDLE);
   assign O_dbg_state   = state_q;

endmodule

// File: tb/tb_uiip_checksum_sched.sv
module tb_uiip_checksum_sched;

   localparam int MAXW = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1, valid0, valid1, last0, last1;
   logic [15:0] data0, data1;
   logic        gnt0, gnt1, cksum_valid, cksum_owner, cksum_zero, err, busy;
   logic [15:0] cksum;
   logic [1:0]  dbg_state;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_q[$];
   logic [15:0] wbuf[0:15];
   logic [15:0] last_cksum = 16'h0000;
   int          last_served = 1;   // so requester 0 is favoured after reset

   uiip_checksum_sched #(.MAX_WORDS(MAXW)) dut (
      .I_clk(clk), .I_reset(rst),
      .I_req0(req0), .I_req1(req1),
      .O_gnt0(gnt0), .O_gnt1(gnt1),
      .I_valid0(valid0), .I_valid1(valid1),
      .I_data0(data0), .I_data1(data1),
      .I_last0(last0), .I_last1(last1),
      .O_cksum(cksum), .O_cksum_valid(cksum_valid),
      .O_cksum_owner(cksum_owner), .O_cksum_zero(cksum_zero),
      .O_err(err), .O_busy(busy), .O_dbg_state(dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // Checksum = inverted, fully folded 32-bit sum of all words.
   function automatic logic [15:0] ref_cksum(input int n);
      logic [31:0] s;
      s = 32'd0;
      for (int i = 0; i < n; i++) s = s + {16'd0, wbuf[i]};
      while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      return ~s[15:0];
   endfunction

   // Round robin: a lone requester wins; on a tie the one not served last wins.
   function automatic int ref_pick(input logic r0, input logic r1);
      if (r0 && r1) return (last_served == 0) ? 1 : 0;
      return r1 ? 1 : 0;
   endfunction

   // ---------------- checker ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_gnt0"},  {31'd0, gnt0}, 0);
      chk({tag, "_gnt1"},  {31'd0, gnt1}, 0);
      chk({tag, "_cksum"}, {16'd0, cksum}, 0);
      chk({tag, "_valid"}, {31'd0, cksum_valid}, 0);
      chk({tag, "_zero"},  {31'd0, cksum_zero}, 0);
      chk({tag, "_owner"}, {31'd0, cksum_owner}, 0);
      chk({tag, "_err"},   {31'd0, err}, 0);
      chk({tag, "_busy"},  {31'd0, busy}, 0);
   endtask

   // ---------------- drivers ----------------
   task automatic set_req(input int who, input logic v);
      if (who == 0) req0 = v; else req1 = v;
   endtask

   task automatic drive(input int who, input logic v, input logic [15:0] d, input logic l);
      if (who == 0) begin valid0 = v; data0 = d; last0 = l; end
      else          begin valid1 = v; data1 = d; last1 = l; end
   endtask

   task automatic noise(input int who);
      drive(who, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
   endtask

   task automatic fill_rand(input int n);
      for (int i = 0; i < n; i++) wbuf[i] = 16'($urandom);
   endtask

   // Polls on falling edges until a grant appears; the first hit is the GRANT cycle.
   task automatic wait_grant(input string tag, output int who);
      who = -1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (gnt0 || gnt1) begin
            who = gnt1 ? 1 : 0;
            break;
         end
      end
      chk({tag, "_grant_seen"}, {31'd0, (who >= 0)}, 1);
      chk({tag, "_gnt_onehot"}, {31'd0, (gnt0 && gnt1)}, 0);
   endtask

   // Entered on the falling edge of the GRANT cycle of requester `who`.
   task automatic run_job(input string tag, input int who, input int n,
                          input bit use_last, input bit keep_req);
      int          other;
      bit          exp_err;
      logic [15:0] exp;
      other   = 1 - who;
      exp_err = !use_last && (n > MAXW);
      if (!exp_err) exp_q.push_back(ref_cksum(n));
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
            drive(who, 1'b0, 16'($urandom), 1'($urandom_range(0, 1)));
            noise(other);
         end
         @(posedge clk); #1;
         drive(who, 1'b1, wbuf[i], use_last && (i == n - 1));
         noise(other);
      end
      @(posedge clk); #1;
      drive(0, 1'b0, 16'd0, 1'b0);
      drive(1, 1'b0, 16'd0, 1'b0);
      if (!keep_req) set_req(who, 1'b0);
      @(negedge clk);
      if (exp_err) begin
         chk({tag, "_err"},   {31'd0, err}, 1);
         chk({tag, "_valid"}, {31'd0, cksum_valid}, 0);
         chk({tag, "_owner"}, {31'd0, cksum_owner}, who);
      end else begin
         exp = exp_q.pop_front();
         last_cksum = exp;
         chk({tag, "_valid"}, {31'd0, cksum_valid}, 1);
         chk({tag, "_cksum"}, {16'd0, cksum}, {16'd0, exp});
         chk({tag, "_zero"},  {31'd0, cksum_zero}, (exp == 16'h0000));
         chk({tag, "_owner"}, {31'd0, cksum_owner}, who);
         chk({tag, "_err"},   {31'd0, err}, 0);
         chk({tag, "_busy"},  {31'd0, busy}, 1);
      end
      chk({tag, "_gnt_drop"}, {30'd0, gnt1, gnt0}, 0);
      last_served = who;
      @(negedge clk);
      chk({tag, "_valid_once"}, {31'd0, cksum_valid}, 0);
      chk({tag, "_err_once"},   {31'd0, err}, 0);
      chk({tag, "_cksum_hold"}, {16'd0, cksum}, {16'd0, last_cksum});
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int w;
      int n;
      int exp_who;
      logic [15:0] hdr[0:9];
      hdr = '{16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011,
              16'h0000, 16'hC0A8, 16'h0001, 16'hC0A8, 16'h00C7};

      rst = 1'b1;
      req0 = 0; req1 = 0;
      drive(0, 1'b0, 16'd0, 1'b0);
      drive(1, 1'b0, 16'd0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;

      // Known IPv4 header from requester 0.
      for (int i = 0; i < 10; i++) wbuf[i] = hdr[i];
      @(posedge clk); #1; set_req(0, 1'b1);
      exp_who = ref_pick(req0, req1);
      wait_grant("hdr", w);
      chk("hdr_owner", w, exp_who);
      run_job("hdr", 0, 10, 1'b1, 1'b0);

      // Same header carrying its own checksum, from requester 1: must verify to zero.
      wbuf[5] = 16'hB861;
      @(posedge clk); #1; set_req(1, 1'b1);
      exp_who = ref_pick(req0, req1);
      wait_grant("rx", w);
      chk("rx_owner", w, exp_who);
      run_job("rx", 1, 10, 1'b1, 1'b0);

      // Reset, then both requesters rise together; winner re-requests at once.
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0; last_served = 1;
      @(posedge clk); #1; set_req(0, 1'b1); set_req(1, 1'b1);
      exp_who = ref_pick(1'b1, 1'b1);
      wait_grant("rr1", w);
      chk("rr1_owner", w, exp_who);
      n = $urandom_range(1, MAXW); fill_rand(n);
      run_job("rr1", w, n, 1'b1, 1'b1);
      exp_who = ref_pick(req0, req1);
      wait_grant("rr2", w);
      chk("rr2_owner", w, exp_who);
      n = $urandom_range(1, MAXW); fill_rand(n);
      run_job("rr2", w, n, 1'b1, 1'b0);
      exp_who = ref_pick(req0, req1);
      wait_grant("rr3", w);
      chk("rr3_owner", w, exp_who);
      n = $urandom_range(1, MAXW); fill_rand(n);
      run_job("rr3", w, n, 1'b1, 1'b0);
      @(posedge clk); #1; set_req(0, 1'b1); set_req(1, 1'b1);
      exp_who = ref_pick(1'b1, 1'b1);
      wait_grant("rr4", w);
      chk("rr4_owner", w, exp_who);
      n = $urandom_range(1, MAXW); fill_rand(n);
      run_job("rr4", w, n, 1'b1, 1'b0);
      exp_who = ref_pick(req0, req1);
      wait_grant("rr5", w);
      chk("rr5_owner", w, exp_who);
      n = $urandom_range(1, MAXW); fill_rand(n);
      run_job("rr5", w, n, 1'b1, 1'b0);

      // Overrun: requester 0 sends MAXW+1 words without last.
      fill_rand(MAXW + 1);
      @(posedge clk); #1; set_req(0, 1'b1);
      exp_who = ref_pick(req0, req1);
      wait_grant("ovr", w);
      chk("ovr_owner", w, exp_who);
      run_job("ovr", 0, MAXW + 1, 1'b0, 1'b0);

      // Exactly MAXW words with last on the final one is a legal job.
      fill_rand(MAXW);
      @(posedge clk); #1; set_req(1, 1'b1);
      wait_grant("full", w);
      run_job("full", 1, MAXW, 1'b1, 1'b0);

      // Abort mid-job, then a fresh job must not see the partial sum.
      @(posedge clk); #1; set_req(1, 1'b1);
      wait_grant("abort", w);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1; drive(1, 1'b1, 16'($urandom), 1'b0);
      end
      @(posedge clk); #1; set_req(1, 1'b0); drive(1, 1'b0, 16'd0, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_busy", {31'd0, busy}, 0);
      chk("abort_gnt", {30'd0, gnt1, gnt0}, 0);
      for (int k = 0; k < 3; k++) begin
         chk("abort_no_result", {30'd0, err, cksum_valid}, 0);
         @(negedge clk);
      end
      n = $urandom_range(1, MAXW); fill_rand(n);
      @(posedge clk); #1; set_req(1, 1'b1);
      wait_grant("post_abort", w);
      run_job("post_abort", 1, n, 1'b1, 1'b0);

      // Random single-requester jobs, including single-word jobs.
      for (int j = 0; j < 8; j++) begin
         int who;
         who = $urandom_range(0, 1);
         n = (j < 2) ? 1 : $urandom_range(1, MAXW);
         fill_rand(n);
         @(posedge clk); #1; set_req(who, 1'b1);
         exp_who = ref_pick(req0, req1);
         wait_grant("rand", w);
         chk("rand_owner", w, exp_who);
         run_job("rand", who, n, 1'b1, 1'b0);
      end

      // End-around carry wrap.
      wbuf[0] = 16'hFFFF; wbuf[1] = 16'h0001;
      @(posedge clk); #1; set_req(0, 1'b1);
      wait_grant("wrap", w);
      run_job("wrap", 0, 2, 1'b1, 1'b0);

      // Reset while the third word of a job is on the bus.
      @(posedge clk); #1; set_req(1, 1'b1);
      wait_grant("rstjob", w);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1; drive(1, 1'b1, 16'($urandom), 1'b0);
      end
      @(posedge clk); #1; drive(1, 1'b1, 16'($urandom), 1'b1); rst = 1'b1;
      @(negedge clk);
      chk_reset_outputs("midrst");
      drive(1, 1'b0, 16'd0, 1'b0); set_req(1, 1'b0);
      @(posedge clk); #1; rst = 1'b0; last_served = 1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("midrst_no_pulse", {29'd0, busy, err, cksum_valid}, 0);
      end

      // Pointer must be back to favouring requester 0.
      @(posedge clk); #1; set_req(0, 1'b1); set_req(1, 1'b1);
      exp_who = ref_pick(1'b1, 1'b1);
      wait_grant("postrst", w);
      chk("postrst_owner", w, exp_who);
      n = $urandom_range(1, MAXW); fill_rand(n);
      run_job("postrst", w, n, 1'b1, 1'b0);
      set_req(0, 1'b0); set_req(1, 1'b0);
      repeat (3) @(posedge clk);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uiip_checksum_sched.md
UIIP_CHECKSUM_SCHED -- requirements
Module: uiip_checksum_sched

Interface
REQ-001 Parameter MAX_WORDS, default 10, maximum 16-bit words per job (20-byte IP header).
REQ-002 I_clk  input  1  sole clock; all logic on its rising edge.
REQ-003 I_reset  input  1  asynchronous, active-high reset.
REQ-004 I_req0 / I_req1  input  1  requester n wants a checksum job; held high until job ends.
REQ-005 O_gnt0 / O_gnt1  output  1  requester n owns the engine; at most one high.
REQ-006 I_valid0 / I_valid1  input  1  word strobe from requester n; ignored unless granted.
REQ-007 I_data0 / I_data1  input  16  header word, big-endian (first byte in [15:8]).
REQ-008 I_last0 / I_last1  input  1  qualifies final word of job, sampled with I_validn.
REQ-009 O_cksum  output  16  one's-complement of folded sum; valid with O_cksum_valid.
REQ-010 O_cksum_valid  output  1  one-cycle result pulse.
REQ-011 O_cksum_owner  output  1  requester index for current result/error.
REQ-012 O_cksum_zero  output  1  high with O_cksum_valid when O_cksum == 16'h0000 (RX header passes).
REQ-013 O_err  output  1  one-cycle pulse on word-count overrun.
REQ-014 O_busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states IDLE, GRANT, ACCUM, DONE; SHALL reset to IDLE.
REQ-016 IDLE: any I_reqn high -> GRANT next cycle; owner chosen round-robin, priority to requester not last served; pointer resets to favour requester 0.
REQ-017 GRANT: assert O_gntn of owner, clear 16-bit accumulator and word counter, -> ACCUM next cycle; first word accepted no earlier than ACCUM.
REQ-018 ACCUM: each owner valid word -> accum <= low16(accum + data) + carry (end-around carry, single cycle, 17-bit intermediate); counter increments.
REQ-019 ACCUM: owner valid with last -> DONE; that word included in sum.
REQ-020 DONE: O_cksum = ~accum, O_cksum_valid = 1, O_cksum_zero per REQ-012, O_gntn dropped, round-robin pointer updated, -> IDLE; result latency = 1 cycle after last word.
REQ-021 O_cksum holds its value until next DONE; O_cksum_valid high only in DONE.
REQ-022 Overrun: valid word arriving when counter == MAX_WORDS and no last -> O_err pulse, no O_cksum_valid, grant dropped, pointer updated, -> IDLE.
REQ-023 Abort: owner deasserts I_reqn while in GRANT/ACCUM -> grant dropped, no result, no error, -> IDLE; accumulated partial sum discarded.
REQ-024 Non-owner I_validn/I_lastn/I_datan SHALL never affect the accumulator.
REQ-025 Both requests high in IDLE: exactly one granted; other granted on next IDLE if still requesting (no starvation, max one job wait).
REQ-026 Single-word job (valid+last on first ACCUM cycle) SHALL be supported.
REQ-027 Gaps (I_validn low) within ACCUM allowed with no timeout.

Reset
REQ-028 On I_reset: state IDLE, all O_gnt 0, O_cksum 16'h0000, O_cksum_valid 0, O_cksum_zero 0, O_cksum_owner 0, O_err 0, O_busy 0, accumulator/counter 0, RR pointer 0.
REQ-029 Reset mid-job SHALL abandon the job immediately with no result pulse after release.

Structure
REQ-030 Shared package holds state encodings, MAX_WORDS default and one's-complement-add function.
REQ-031 One sub-module natural: uiip_ones_add16 (combinational 16-bit end-around-carry adder) instantiated by the accumulator.

Verification
REQ-032 Req0 alone, 10 words 4500 0073 0000 4000 4011 0000 C0A8 0001 C0A8 00C7 -> O_cksum 16'hB861, owner 0, valid one cycle after last.
REQ-033 Req1 alone, same header with 16'hB861 in word 5 -> O_cksum 16'h0000, O_cksum_zero 1.
REQ-034 Req0 and req1 rise same cycle from reset -> req0 served first, req1 granted next; third simultaneous round -> req1 first.
REQ-035 Req0 sends 11 words with no last (MAX_WORDS 10) -> O_err pulse on 11th word, no O_cksum_valid, grant dropped.
REQ-036 Words FFFF,0001 (last) -> sum wraps to 0001, O_cksum 16'hFFFE; then I_reset asserted during next job's 3rd word -> all outputs at reset values, no result pulse.
